// File: rtl/timer_irq_master.sv
// Avalon-MM master for an interval-timer slave: configures and starts the timer,
// clears each timeout, counts ticks and periodically reads back a counter snapshot.
module timer_irq_master #(
  parameter logic [31:0] PERIOD     = 32'h0000C34F,
  parameter int unsigned SNAP_EVERY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [15:0] writedata,
  input  logic [15:0] readdata,
  input  logic        irq,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic [15:0] snapshot,
  output logic        snapshot_valid,
  output logic        busy
);

  localparam int unsigned      DIV_W    = (SNAP_EVERY > 1) ? $clog2(SNAP_EVERY) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SNAP_EVERY - 1);

  localparam logic [2:0]  A_STATUS  = 3'd0;
  localparam logic [2:0]  A_CONTROL = 3'd1;
  localparam logic [2:0]  A_PER_L   = 3'd2;
  localparam logic [2:0]  A_PER_H   = 3'd3;
  localparam logic [2:0]  A_SNAP_L  = 3'd4;
  localparam logic [15:0] CTRL_STOP  = 16'h0008;
  localparam logic [15:0] CTRL_START = 16'h0007;

  typedef enum logic [3:0] {
    S_IDLE, S_STOP, S_PER_L, S_PER_H, S_START, S_WAIT,
    S_CLR, S_SNAP_W, S_SNAP_A, S_SNAP_C, S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;

  logic [2:0]  r_address;
  logic        r_chipselect;
  logic        r_write_n;
  logic [15:0] r_writedata;
  logic        r_tick;
  logic [31:0] r_tick_count;
  logic [15:0] r_snapshot;
  logic        r_snapshot_valid;
  logic        r_busy;

  logic [2:0]  w_address;
  logic        w_chipselect;
  logic        w_write_n;
  logic [15:0] w_writedata;

  // Next state and snapshot divider
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    unique case (r_state)
      S_IDLE:   if (enable) w_state_nxt = S_STOP;
      S_STOP:   w_state_nxt = S_PER_L;
      S_PER_L:  w_state_nxt = S_PER_H;
      S_PER_H:  w_state_nxt = S_START;
      S_START:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!enable)  w_state_nxt = S_HALT;
        else if (irq) w_state_nxt = S_CLR;
      end
      S_CLR: begin
        if ((SNAP_EVERY != 0) && (r_div == DIV_LAST)) begin
          w_div_nxt   = '0;
          w_state_nxt = S_SNAP_W;
        end else begin
          w_div_nxt   = r_div + 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_SNAP_W: w_state_nxt = S_SNAP_A;
      S_SNAP_A: w_state_nxt = S_SNAP_C;
      S_SNAP_C: w_state_nxt = S_WAIT;
      S_HALT:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Bus values for the state being entered, so registered outputs track the state
  always_comb begin
    w_address    = 3'd0;
    w_chipselect = 1'b0;
    w_write_n    = 1'b1;
    w_writedata  = 16'h0000;
    unique case (w_state_nxt)
      S_STOP, S_HALT: begin
        w_address = A_CONTROL; w_chipselect = 1'b1; w_write_n = 1'b0; w_writedata = CTRL_STOP;
      end
      S_PER_L: begin
        w_address = A_PER_L; w_chipselect = 1'b1; w_write_n = 1'b0; w_writedata = PERIOD[15:0];
      end
      S_PER_H: begin
        w_address = A_PER_H; w_chipselect = 1'b1; w_write_n = 1'b0; w_writedata = PERIOD[31:16];
      end
      S_START: begin
        w_address = A_CONTROL; w_chipselect = 1'b1; w_write_n = 1'b0; w_writedata = CTRL_START;
      end
      S_CLR: begin
        w_address = A_STATUS; w_chipselect = 1'b1; w_write_n = 1'b0;
      end
      S_SNAP_W: begin
        w_address = A_SNAP_L; w_chipselect = 1'b1; w_write_n = 1'b0;
      end
      S_SNAP_A, S_SNAP_C: w_address = A_SNAP_L;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_div            <= '0;
      r_address        <= 3'd0;
      r_chipselect     <= 1'b0;
      r_write_n        <= 1'b1;
      r_writedata      <= 16'h0000;
      r_tick           <= 1'b0;
      r_tick_count     <= 32'd0;
      r_snapshot       <= 16'h0000;
      r_snapshot_valid <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_div            <= w_div_nxt;
      r_address        <= w_address;
      r_chipselect     <= w_chipselect;
      r_write_n        <= w_write_n;
      r_writedata      <= w_writedata;
      r_tick           <= (w_state_nxt == S_CLR);
      r_snapshot_valid <= (w_state_nxt == S_SNAP_C);
      r_busy           <= (w_state_nxt != S_IDLE);
      if ((r_state == S_IDLE) && enable) r_tick_count <= 32'd0;
      else if (r_state == S_CLR)         r_tick_count <= r_tick_count + 32'd1;
      // readdata reflects the address presented during SNAP_A
      if (r_state == S_SNAP_C) r_snapshot <= readdata;
    end
  end

  assign address        = r_address;
  assign chipselect     = r_chipselect;
  assign write_n        = r_write_n;
  assign writedata      = r_writedata;
  assign tick           = r_tick;
  assign tick_count     = r_tick_count;
  assign snapshot       = r_snapshot;
  assign snapshot_valid = r_snapshot_valid;
  assign busy           = r_busy;

endmodule

// File: tb/tb_timer_irq_master.sv
// Directed bench for timer_irq_master with a behavioural interval-timer slave.
module tb_timer_irq_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;

  logic [2:0]  address;
  logic        chipselect, write_n, irq, tick, snapshot_valid, busy;
  logic [15:0] writedata, readdata, snapshot;
  logic [31:0] tick_count;

  logic [2:0]  d_address;
  logic        d_chipselect, d_write_n, d_tick, d_snapshot_valid, d_busy;
  logic [15:0] d_writedata, d_snapshot;
  logic [31:0] d_tick_count;
  logic [15:0] zero16 = 16'h0000;
  logic        zero1 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_irq_master #(.PERIOD(32'd9), .SNAP_EVERY(4)) u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq), .tick(tick), .tick_count(tick_count),
    .snapshot(snapshot), .snapshot_valid(snapshot_valid), .busy(busy)
  );

  timer_irq_master u_dut_def (
    .clk(clk), .reset(reset), .enable(enable),
    .address(d_address), .chipselect(d_chipselect), .write_n(d_write_n), .writedata(d_writedata),
    .readdata(zero16), .irq(zero1), .tick(d_tick), .tick_count(d_tick_count),
    .snapshot(d_snapshot), .snapshot_valid(d_snapshot_valid), .busy(d_busy)
  );

  // Interval-timer slave model
  logic [31:0] m_period, m_cnt;
  logic        m_run, m_cont, m_ito, m_to;
  logic [15:0] m_snap, m_rd;
  logic        m_snap_ovr = 1'b1;

  always_comb begin
    m_rd = 16'h0000;
    case (address)
      3'd0: m_rd = {15'd0, m_to};
      3'd1: m_rd = {13'd0, 1'b0, m_cont, m_ito};
      3'd2: m_rd = m_period[15:0];
      3'd3: m_rd = m_period[31:16];
      3'd4: m_rd = m_snap;
      default: m_rd = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_period <= '0; m_cnt <= '0; m_run <= 1'b0; m_cont <= 1'b0;
      m_ito <= 1'b0; m_to <= 1'b0; m_snap <= '0; readdata <= '0;
    end else begin
      readdata <= m_rd;
      if (m_run) begin
        if (m_cnt == 32'd0) begin
          m_cnt <= m_period;
          m_to  <= 1'b1;
          if (!m_cont) m_run <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 32'd1;
        end
      end
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ito  <= writedata[0];
            m_cont <= writedata[1];
            if (writedata[2]) m_run <= 1'b1;
            if (writedata[3]) m_run <= 1'b0;
          end
          3'd2: begin m_period[15:0]  <= writedata; m_cnt <= {m_period[31:16], writedata}; end
          3'd3: begin m_period[31:16] <= writedata; m_cnt <= {writedata, m_period[15:0]}; end
          3'd4: m_snap <= m_snap_ovr ? 16'h1234 : m_cnt[15:0];
          default: ;
        endcase
      end
    end
  end

  assign irq = m_to & m_ito;

  // Pulse and write counters
  int n_tick = 0;
  int n_sv = 0;
  int n_wr = 0;
  always @(posedge clk) begin
    if (tick) n_tick++;
    if (snapshot_valid) n_sv++;
    if (chipselect && !write_n) n_wr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_irq(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (irq) begin ok = 1'b1; break; end
    end
  endtask

  logic [2:0]  exp_a [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
  logic [15:0] exp_dd[4] = '{16'h0008, 16'hC34F, 16'h0000, 16'h0007};
  logic [15:0] exp_ds[4] = '{16'h0008, 16'h0009, 16'h0000, 16'h0007};

  initial begin
    logic ok;
    int   t0, s0, w0;

    repeat (3) @(negedge clk);
    chk("rst_bus", {11'd0, chipselect, write_n, address, writedata}, {11'd0, 1'b0, 1'b1, 3'd0, 16'h0});
    chk("rst_outs", {28'd0, tick, snapshot_valid, busy, 1'b0}, 32'd0);
    chk("rst_tick_count", tick_count, 32'd0);
    chk("rst_snapshot", {16'd0, snapshot}, 32'd0);

    reset  = 1'b0;
    enable = 1'b1;
    chk("busy_cycle0", {31'd0, busy}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("def_wr%0d", c + 1), {11'd0, d_chipselect, d_write_n, d_address, d_writedata},
          {11'd0, 1'b1, 1'b0, exp_a[c], exp_dd[c]});
      chk($sformatf("dut_wr%0d", c + 1), {11'd0, chipselect, write_n, address, writedata},
          {11'd0, 1'b1, 1'b0, exp_a[c], exp_ds[c]});
      chk($sformatf("busy_cycle%0d", c + 1), {30'd0, busy, d_busy}, 32'd3);
    end

    t0 = n_tick;
    s0 = n_sv;
    for (int k = 1; k <= 8; k++) begin
      wait_irq(40, ok);
      chk($sformatf("irq_seen%0d", k), {31'd0, ok}, 32'd1);
      @(negedge clk);
      chk($sformatf("clr_bus%0d", k), {11'd0, chipselect, write_n, address, writedata},
          {11'd0, 1'b1, 1'b0, 3'd0, 16'h0});
      chk($sformatf("clr_tick%0d", k), {31'd0, tick}, 32'd1);
      @(negedge clk);
      chk($sformatf("tick_count%0d", k), tick_count, 32'(k));
      if (k % 4 == 0) begin
        chk($sformatf("snapw_bus%0d", k), {11'd0, chipselect, write_n, address, writedata},
            {11'd0, 1'b1, 1'b0, 3'd4, 16'h0});
        @(negedge clk);
        chk($sformatf("snapa_bus%0d", k), {27'd0, chipselect, write_n, address}, {27'd0, 1'b0, 1'b1, 3'd4});
        @(negedge clk);
        chk($sformatf("snapc_valid%0d", k), {31'd0, snapshot_valid}, 32'd1);
        @(negedge clk);
        chk($sformatf("snap_val%0d", k), {16'd0, snapshot}, {16'd0, (k == 4) ? 16'h1234 : m_snap});
        m_snap_ovr = 1'b0;
      end
    end
    chk("tick_pulses", 32'(n_tick - t0), 32'd8);
    chk("snap_pulses", 32'(n_sv - s0), 32'd2);

    // tick_count wrap
    force u_dut.r_tick_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release u_dut.r_tick_count;
    chk("preload", tick_count, 32'hFFFF_FFFF);
    wait_irq(40, ok);
    chk("irq_seen_wrap", {31'd0, ok}, 32'd1);
    @(negedge clk);
    chk("wrap_tick", {31'd0, tick}, 32'd1);
    @(negedge clk);
    chk("wrap_count", tick_count, 32'd0);

    // enable drop in WAIT
    enable = 1'b0;
    @(negedge clk);
    chk("halt_bus", {11'd0, chipselect, write_n, address, writedata}, {11'd0, 1'b1, 1'b0, 3'd1, 16'h0008});
    @(negedge clk);
    chk("idle_bus", {10'd0, busy, chipselect, write_n, address, writedata}, {10'd0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0});
    w0 = n_wr;
    repeat (20) @(negedge clk);
    chk("no_writes_idle", 32'(n_wr - w0), 32'd0);

    // reset during PER_H
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("at_per_h", {29'd0, address}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_bus", {11'd0, chipselect, write_n, address, writedata}, {11'd0, 1'b0, 1'b1, 3'd0, 16'h0});
    chk("mid_rst_outs", {13'd0, busy, tick, snapshot_valid, snapshot}, 32'd0);
    chk("mid_rst_count", tick_count, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_stop", {11'd0, chipselect, write_n, address, writedata}, {11'd0, 1'b1, 1'b0, 3'd1, 16'h0008});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_irq_master.md
Name: timer_irq_master

Overview:
- Avalon-MM master that drives the 16-bit-data, 3-bit-address interval-timer slave from the initiator side.
- Sequence:
  - Stops the timer.
  - Writes the period registers, which force a reload.
  - Starts the timer in continuous mode with IRQ enabled.
  - Services each irq by clearing the status register.
  - Every N timeouts, triggers a counter snapshot and reads it back.
- Sits between the timer slave and fabric logic that needs a tick count without a CPU.

Parameters:
- PERIOD, 32'h0000C34F, value written to period_l (bits 15:0) and period_h (bits 31:16).
- SNAP_EVERY, 4, take a snapshot after every SNAP_EVERY-th timeout; 0 disables snapshots.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run the timer, 0 = stop it and return to idle.
- address  out  3  slave register address: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- chipselect  out  1  slave select, asserted for writes only.
- write_n  out  1  active-low write strobe.
- writedata  out  16  write data.
- readdata  in  16  slave read data. The slave registers it one cycle after address is presented; there is no read strobe and no waitrequest.
- irq  in  1  slave level interrupt (timeout_occurred AND ITO).
- tick  out  1  one-cycle pulse per serviced timeout.
- tick_count  out  32  serviced timeouts since leaving IDLE; wraps 0xFFFFFFFF -> 0.
- snapshot  out  16  last counter value read back from snap_l.
- snapshot_valid  out  1  one-cycle pulse when snapshot updates.
- busy  out  1  1 in every state except IDLE.

Behaviour:
- Moore FSM. Bus outputs depend only on the current state. Each slave write takes exactly 1 cycle: chipselect=1, write_n=0.
- Idle bus values: chipselect=0, write_n=1, address=0, writedata=0.
- Reset value of every output is 0, except write_n=1. FSM goes to IDLE; internal snapshot divider = 0.
- States:
  - IDLE: bus idle. When enable=1: clear tick_count to 0, go to STOP.
  - STOP: write addr 1, data 16'h0008 (STOP). -> PER_L.
  - PER_L: write addr 2, data PERIOD[15:0]. -> PER_H.
  - PER_H: write addr 3, data PERIOD[31:16]. -> START.
  - START: write addr 1, data 16'h0007 (START|CONT|ITO). -> WAIT.
  - WAIT: bus idle.
    - enable=0 -> HALT (enable has priority over irq).
    - irq=1 -> CLR.
  - CLR: write addr 0, data 0 (clears timeout). tick=1 this cycle; tick_count increments at the end of the cycle.
    - If SNAP_EVERY!=0 and divider == SNAP_EVERY-1: divider <= 0, -> SNAP_W.
    - Else: divider++, -> WAIT.
  - SNAP_W: write addr 4, data 0 (latches the counter). -> SNAP_A.
  - SNAP_A: address=4, chipselect=0, write_n=1. -> SNAP_C.
  - SNAP_C: address=4. Capture readdata into snapshot at the end of the cycle; snapshot_valid=1 this cycle. -> WAIT.
  - HALT: write addr 1, data 16'h0008. -> IDLE.
- Latencies:
  - enable rise to first bus write (STOP) = 1 cycle.
  - Timer running after START write = 5 cycles from enable.
  - irq-high cycle in WAIT to CLR write = 1 cycle.
- Boundary conditions:
  - irq still high on return to WAIT (a new timeout arrived during SNAP_*): serviced immediately; no timeout is lost.
  - A timeout coinciding with the CLR write is lost, because the slave gives status-write priority. PERIOD+1 must exceed 5 clk cycles.
  - enable dropping outside WAIT: the current sequence runs to WAIT, then goes to HALT. Configuration sequences are never aborted mid-way.
  - enable re-asserted while in HALT: go to IDLE first, then restart on the next cycle. tick_count is cleared on restart.
  - Reset mid-sequence: immediate return to IDLE with idle bus values; the slave is left in whatever state was last written.

Test Plan:
- Reset, enable=1 at cycle 0 -> writes in cycles 1-4: (1,0x0008), (2,0xC34F), (3,0x0000), (1,0x0007). busy=1 from cycle 1.
- Model slave, PERIOD=9 (10-cycle timeout); run 8 timeouts -> 8 tick pulses, tick_count=8, each CLR write (addr 0) exactly 1 cycle after irq rises.
- SNAP_EVERY=4, slave counter=0x1234 at the snap write -> snapshot=0x1234. snapshot_valid pulses twice over 8 timeouts, each 2 cycles after the SNAP_W write.
- Preload tick_count near wrap (force 0xFFFFFFFF) and service 1 irq -> tick_count=0, tick=1.
- enable 1->0 while in WAIT -> next cycle write (1,0x0008), then IDLE. busy=0, bus idle, no further writes.
- Assert reset during the PER_H cycle -> next cycle: write_n=1, chipselect=0, all outputs 0, FSM in IDLE. Re-enable restarts at STOP.
